// File: rtl/cr16_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cr16_issue_ctrl
// Description : Issue/decode controller in front of the CR16 ALU. Accepts one
//               16-bit instruction per handshake, decodes it, reads the
//               register file, drives the ALU operands/opcode/carry-in and
//               writes back the result and the status flags (PSR).
//               Sequence: IDLE -> DECODE -> EXEC -> WB, one instruction per
//               four clocks.
// Config      : ISSUE_MUL_EN - when defined, MUL (op=0000, opext=1110) and
//               MULI (op=1110) decode with alu_op=1110; otherwise both are
//               dropped as illegal.
// Ports       : clk, reset (async, active high)
//               inst_valid/inst_ready/inst   - instruction handshake
//               rf_raddr_a/b, rf_rdata_a/b   - register file read ports
//               alu_r1/r2/op/cin, alu_out/flags - ALU interface
//               rf_we/rf_waddr/rf_wdata      - register file write port
//               psr, done, illegal           - status and retire pulses
// Revision    : 1.0 - initial release
// ============================================================================
module cr16_issue_ctrl #(
  parameter int DATA_W = 16,
  parameter int RF_AW  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_valid,
  output logic              inst_ready,
  input  logic [15:0]       inst,
  output logic [RF_AW-1:0]  rf_raddr_a,
  output logic [RF_AW-1:0]  rf_raddr_b,
  input  logic [DATA_W-1:0] rf_rdata_a,
  input  logic [DATA_W-1:0] rf_rdata_b,
  output logic [DATA_W-1:0] alu_r1,
  output logic [DATA_W-1:0] alu_r2,
  output logic [3:0]        alu_op,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [4:0]        alu_flags,
  output logic              rf_we,
  output logic [RF_AW-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [4:0]        psr,
  output logic              done,
  output logic              illegal
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_t;

  // Bit n set => code n is a legal register-form opext / immediate-form op.
`ifdef ISSUE_MUL_EN
  localparam logic [15:0] ARITH_MASK = 16'h6EEE;
`else
  localparam logic [15:0] ARITH_MASK = 16'h2EEE;
`endif
  // Bit n set => alu_op n (ADD/ADDU/ADDC/SUB/SUBC/CMP) loads the PSR.
  localparam logic [15:0] PSR_MASK   = 16'h0EE0;
  localparam logic [3:0]  OP_REG     = 4'h0;
  localparam logic [3:0]  OP_SHIFT   = 4'h8;
  localparam logic [3:0]  ALU_LSH    = 4'h8;
  localparam logic [3:0]  ALU_ASHU   = 4'hF;
  localparam logic [3:0]  ALU_CMP    = 4'hB;

  state_t              state_q, state_d;
  logic [15:0]         inst_q, inst_d;
  logic [DATA_W-1:0]   alu_r1_q, alu_r1_d;
  logic [DATA_W-1:0]   alu_r2_q, alu_r2_d;
  logic [3:0]          alu_op_q, alu_op_d;
  logic                alu_cin_q, alu_cin_d;
  logic                we_q, we_d;
  logic                psr_ld_q, psr_ld_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic [4:0]          flags_q, flags_d;
  logic [4:0]          psr_q, psr_d;

  // Decode results, valid while in DECODE (inst_q holds the accepted word).
  logic                dec_legal;
  logic [3:0]          dec_op;
  logic [DATA_W-1:0]   dec_r1;
  logic                dec_we;
  logic                dec_psr_ld;

  logic [3:0]          op_f, ext_f;
  logic [DATA_W-1:0]   imm8_zx, imm8_sx, imm5_sx;

  assign op_f    = inst_q[15:12];
  assign ext_f   = inst_q[7:4];
  assign imm8_zx = {{(DATA_W-8){1'b0}}, inst_q[7:0]};
  assign imm8_sx = {{(DATA_W-8){inst_q[7]}}, inst_q[7:0]};
  assign imm5_sx = {{(DATA_W-5){inst_q[4]}}, inst_q[4:0]};

  // Read addresses follow the held instruction, so RF data is ready in DECODE.
  assign rf_raddr_a = RF_AW'(inst_q[3:0]);
  assign rf_raddr_b = RF_AW'(inst_q[11:8]);

  always_comb begin
    dec_legal  = 1'b0;
    dec_op     = 4'h0;
    dec_r1     = '0;
    case (op_f)
      OP_REG: begin
        if (ARITH_MASK[ext_f]) begin
          dec_legal = 1'b1;
          dec_op    = ext_f;
          dec_r1    = rf_rdata_a;
        end
      end
      OP_SHIFT: begin
        // opext 000x / 001x carry a 5-bit signed shift count in inst[4:0].
        if (ext_f == 4'h4) begin
          dec_legal = 1'b1;
          dec_op    = ALU_LSH;
          dec_r1    = rf_rdata_a;
        end else if (ext_f[3:1] == 3'b000) begin
          dec_legal = 1'b1;
          dec_op    = ALU_LSH;
          dec_r1    = imm5_sx;
        end else if (ext_f == 4'h6) begin
          dec_legal = 1'b1;
          dec_op    = ALU_ASHU;
          dec_r1    = rf_rdata_a;
        end else if (ext_f[3:1] == 3'b001) begin
          dec_legal = 1'b1;
          dec_op    = ALU_ASHU;
          dec_r1    = imm5_sx;
        end
      end
      default: begin
        if (ARITH_MASK[op_f]) begin
          dec_legal = 1'b1;
          dec_op    = op_f;
          // Logical immediates (ANDI/ORI/XORI) zero-extend, the rest sign-extend.
          dec_r1    = (op_f <= 4'h3) ? imm8_zx : imm8_sx;
        end
      end
    endcase
    dec_we     = dec_legal && (dec_op != ALU_CMP);
    dec_psr_ld = dec_legal && PSR_MASK[dec_op];
  end

  always_comb begin
    state_d   = state_q;
    inst_d    = inst_q;
    alu_r1_d  = alu_r1_q;
    alu_r2_d  = alu_r2_q;
    alu_op_d  = alu_op_q;
    alu_cin_d = alu_cin_q;
    we_d      = we_q;
    psr_ld_d  = psr_ld_q;
    res_d     = res_q;
    flags_d   = flags_q;
    psr_d     = psr_q;
    case (state_q)
      ST_IDLE: begin
        if (inst_valid) begin
          inst_d  = inst;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec_legal) begin
          alu_r1_d  = dec_r1;
          alu_r2_d  = rf_rdata_b;
          alu_op_d  = dec_op;
          // Carry-in is the PSR left by the previous instruction.
          alu_cin_d = psr_q[0];
          we_d      = dec_we;
          psr_ld_d  = dec_psr_ld;
          state_d   = ST_EXEC;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_EXEC: begin
        res_d   = alu_out;
        flags_d = alu_flags;
        state_d = ST_WB;
      end
      ST_WB: begin
        if (psr_ld_q) begin
          psr_d = flags_q;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      inst_q    <= '0;
      alu_r1_q  <= '0;
      alu_r2_q  <= '0;
      alu_op_q  <= '0;
      alu_cin_q <= 1'b0;
      we_q      <= 1'b0;
      psr_ld_q  <= 1'b0;
      res_q     <= '0;
      flags_q   <= '0;
      psr_q     <= '0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      alu_r1_q  <= alu_r1_d;
      alu_r2_q  <= alu_r2_d;
      alu_op_q  <= alu_op_d;
      alu_cin_q <= alu_cin_d;
      we_q      <= we_d;
      psr_ld_q  <= psr_ld_d;
      res_q     <= res_d;
      flags_q   <= flags_d;
      psr_q     <= psr_d;
    end
  end

  assign inst_ready = (state_q == ST_IDLE);
  assign illegal    = (state_q == ST_DECODE) && !dec_legal;
  assign done       = (state_q == ST_WB);
  assign rf_we      = (state_q == ST_WB) && we_q;
  assign rf_waddr   = RF_AW'(inst_q[11:8]);
  assign rf_wdata   = res_q;
  assign alu_r1     = alu_r1_q;
  assign alu_r2     = alu_r2_q;
  assign alu_op     = alu_op_q;
  assign alu_cin    = alu_cin_q;
  assign psr        = psr_q;

endmodule
`default_nettype wire

// File: tb/tb_cr16_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cr16_issue_ctrl
// Description : Directed self-checking bench for cr16_issue_ctrl. Provides a
//               register-file model and a small ALU model, issues hand-picked
//               instructions and compares against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cr16_issue_ctrl;
  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          inst_valid;
  logic          inst_ready;
  logic [15:0]   inst;
  logic [AW-1:0] rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [DW-1:0] rf_rdata_a, rf_rdata_b, rf_wdata;
  logic [DW-1:0] alu_r1, alu_r2, alu_out;
  logic [3:0]    alu_op;
  logic          alu_cin;
  logic [4:0]    alu_flags;
  logic          rf_we;
  logic [4:0]    psr;
  logic          done;
  logic          illegal;

  int n_vec = 0;
  int n_err = 0;
  int we_cnt = 0;

  logic [DW-1:0] rf [16];
  logic          tb_wr = 1'b0;
  logic [3:0]    tb_addr = 4'h0;
  logic [DW-1:0] tb_data = '0;

  always #5 clk = ~clk;

  cr16_issue_ctrl #(.DATA_W(DW), .RF_AW(AW)) dut (
    .clk(clk), .reset(reset), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b), .alu_r1(alu_r1),
    .alu_r2(alu_r2), .alu_op(alu_op), .alu_cin(alu_cin), .alu_out(alu_out),
    .alu_flags(alu_flags), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .psr(psr), .done(done), .illegal(illegal)
  );

  // Register file model: combinational reads, bench preload has priority.
  assign rf_rdata_a = rf[rf_raddr_a];
  assign rf_rdata_b = rf[rf_raddr_b];
  always @(posedge clk) begin
    if (tb_wr) rf[tb_addr] <= tb_data;
    else if (rf_we) rf[rf_waddr] <= rf_wdata;
    if (rf_we) we_cnt <= we_cnt + 1;
  end

  // ALU model; flags are {Z,N,F,L,C}.
  logic [16:0] s;
  always_comb begin
    s         = '0;
    alu_out   = '0;
    alu_flags = '0;
    case (alu_op)
      4'h1: alu_out = alu_r2 & alu_r1;
      4'h2: alu_out = alu_r2 | alu_r1;
      4'h3: alu_out = alu_r2 ^ alu_r1;
      4'h5, 4'h6: begin s = {1'b0, alu_r2} + {1'b0, alu_r1}; alu_out = s[15:0]; end
      4'h7: begin s = {1'b0, alu_r2} + {1'b0, alu_r1} + {16'b0, alu_cin}; alu_out = s[15:0]; end
      4'h9: alu_out = alu_r2 - alu_r1;
      4'hA: alu_out = alu_r2 - alu_r1 - {15'b0, alu_cin};
      4'h8: alu_out = alu_r2 ^ alu_r1;
      4'hF: alu_out = ~alu_r2;
      4'hD: alu_out = alu_r1;
      4'hE: alu_out = alu_r2 * alu_r1;
      default: alu_out = '0;
    endcase
    if (alu_op == 4'hB) alu_flags = {(alu_r1 == alu_r2), 3'b000, (alu_r1 > alu_r2)};
    else                alu_flags = {(alu_out == '0), alu_out[15], 2'b00, s[16]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [3:0] a, input logic [DW-1:0] d);
    tb_wr = 1'b1; tb_addr = a; tb_data = d;
    @(negedge clk);
    tb_wr = 1'b0;
  endtask

  // Waits (bounded) for inst_ready, presents w for one edge; returns at the
  // negedge inside DECODE.
  task automatic issue(input logic [15:0] w);
    int k;
    k = 0;
    while (!inst_ready && k < 20) begin @(negedge clk); k++; end
    if (!inst_ready) check("issue_timeout", 0, 1);
    inst = w; inst_valid = 1'b1;
    @(negedge clk);
    inst_valid = 1'b0;
  endtask

  task automatic run(input string tag, input logic [15:0] w, input logic [3:0] e_op,
                     input logic [15:0] e_r1, input logic [15:0] e_r2, input logic e_cin,
                     input logic e_we, input logic [15:0] e_wd, input logic [4:0] e_psr);
    issue(w);
    check({tag, ".illegal"}, illegal, 0);
    check({tag, ".ready_busy"}, inst_ready, 0);
    @(negedge clk);
    check({tag, ".alu_op"}, alu_op, e_op);
    check({tag, ".alu_r1"}, alu_r1, e_r1);
    check({tag, ".alu_r2"}, alu_r2, e_r2);
    check({tag, ".alu_cin"}, alu_cin, e_cin);
    @(negedge clk);
    check({tag, ".rf_we"}, rf_we, e_we);
    check({tag, ".done"}, done, 1);
    if (e_we) begin
      check({tag, ".waddr"}, rf_waddr, w[11:8]);
      check({tag, ".wdata"}, rf_wdata, e_wd);
    end
    @(negedge clk);
    check({tag, ".psr"}, psr, e_psr);
    check({tag, ".ready"}, inst_ready, 1);
  endtask

  task automatic run_illegal(input string tag, input logic [15:0] w, input logic [4:0] e_psr);
    logic seen;
    issue(w);
    check({tag, ".illegal"}, illegal, 1);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      seen = seen | rf_we | done | illegal;
    end
    check({tag, ".no_side_effect"}, seen, 0);
    check({tag, ".psr"}, psr, e_psr);
    check({tag, ".ready"}, inst_ready, 1);
  endtask

  initial begin
    logic [7:0] rdy_v, done_v;
    int we_snap;
    logic [15:0] r3_snap;
    reset = 1'b1; inst_valid = 1'b0; inst = 16'h0;
    @(negedge clk);
    @(negedge clk);
    check("rst.ready", inst_ready, 1);
    check("rst.rf_we", rf_we, 0);
    check("rst.done", done, 0);
    check("rst.illegal", illegal, 0);
    check("rst.psr", psr, 0);
    preload(4'h1, 16'h0000);
    preload(4'h2, 16'h0007);
    preload(4'h3, 16'h0005);
    preload(4'h4, 16'h0003);
    reset = 1'b0;
    @(negedge clk);

    run("add",   16'h0352, 4'h5, 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h000C, 5'h00);
    run("addi",  16'h51FF, 4'h5, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 5'h08);
    run("andi",  16'h11FF, 4'h1, 16'h00FF, 16'hFFFF, 1'b0, 1'b1, 16'h00FF, 5'h08);
    run("cmp",   16'h04B2, 4'hB, 16'h0007, 16'h0003, 1'b0, 1'b0, 16'h0000, 5'h01);
    run("addc",  16'h0372, 4'h7, 16'h0007, 16'h000C, 1'b1, 1'b1, 16'h0014, 5'h00);
    run("lshi",  16'h841E, 4'h8, 16'hFFFE, 16'h0003, 1'b0, 1'b1, 16'hFFFD, 5'h00);
    run("ashu",  16'h8464, 4'hF, 16'hFFFD, 16'hFFFD, 1'b0, 1'b1, 16'h0002, 5'h00);
    run("cmp2",  16'h04B2, 4'hB, 16'h0007, 16'h0002, 1'b0, 1'b0, 16'h0000, 5'h01);
    run_illegal("op4", 16'h4123, 5'h01);
`ifdef ISSUE_MUL_EN
    run("mul",   16'h03E2, 4'hE, 16'h0007, 16'h0014, 1'b1, 1'b1, 16'h008C, 5'h01);
`else
    run_illegal("mul",  16'h03E2, 5'h01);
    run_illegal("muli", 16'hE1FF, 5'h01);
`endif

    // Valid held high: acceptance only every fourth clock.
    inst = 16'h0352; inst_valid = 1'b1;
    rdy_v = '0; done_v = '0;
    for (int k = 0; k < 8; k++) begin
      rdy_v[k]  = inst_ready;
      done_v[k] = done;
      if (k == 7) inst_valid = 1'b0;
      @(negedge clk);
    end
    check("b2b.ready_pattern", rdy_v, 8'b0001_0001);
    check("b2b.done_pattern", done_v, 8'b1000_1000);
    @(negedge clk);

    // Make PSR non-zero, then abort an ADD in EXEC with reset.
    run("cmp3", 16'h04B2, 4'hB, 16'h0007, 16'h0002, 1'b0, 1'b0, 16'h0000, 5'h01);
    we_snap = we_cnt;
    r3_snap = rf[3];
    issue(16'h0352);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rstmid.psr_async", psr, 0);
    check("rstmid.ready_async", inst_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    check("rstmid.no_we", we_cnt, we_snap);
    check("rstmid.r3_kept", rf[3], r3_snap);
    check("rstmid.psr", psr, 0);
    check("rstmid.ready", inst_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
